// File: rtl/cvp14_pkg.sv
// Shared types and widths for the CVP14 memory responder slice.
package cvp14_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_READ,
        REQ_WRITE,
        REQ_BAD
    } req_e;

    // True when the word address has any bit set above the implemented range.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] a, input int bits);
        if (bits >= ADDR_W) return 1'b0;
        return (a >> bits) != '0;
    endfunction

endpackage

// File: rtl/cvp14_mem_responder_if.sv
// Core-side request/response bus of the CVP14 memory responder.
interface cvp14_mem_responder_if;
    import cvp14_pkg::*;

    logic [ADDR_W-1:0] Addr;
    logic              RD;
    logic              WR;
    logic [WORD_W-1:0] DataIn;
    logic [WORD_W-1:0] DataOut;
    logic              Ack;
    logic              Busy;
    logic              Err;

    modport master (
        output Addr, RD, WR, DataIn,
        input  DataOut, Ack, Busy, Err
    );

    modport slave (
        input  Addr, RD, WR, DataIn,
        output DataOut, Ack, Busy, Err
    );

endinterface

// File: rtl/cvp14_word_array.sv
// Word storage: one combinational read port, one synchronous write port.
module cvp14_word_array
    import cvp14_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WORD_W-1:0]    wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WORD_W-1:0]    rdata
);

    logic [WORD_W-1:0] mem_q [2**ADDR_BITS];

    // NOTE: the array has no reset branch; contents survive reset and a
    // reset loop over every word would not map onto RAM macros.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cvp14_mem_responder.sv
// CVP14 memory responder: IDLE/WAIT/RESP handshake FSM in front of a word array.
module cvp14_mem_responder
    import cvp14_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int WAIT_CYC  = 1
) (
    input  logic Clk1,
    input  logic Reset,
    cvp14_mem_responder_if.slave bus
);

    localparam logic [2:0] CNT_LOAD = 3'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

    state_e            state_q, state_d;
    req_e              type_q, type_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] rdata;
    logic              we;

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.RD && bus.WR) begin
                    type_d  = REQ_BAD;
                    state_d = ST_RESP;
                end else if (bus.RD || bus.WR) begin
                    addr_d = bus.Addr;
                    data_d = bus.DataIn;
                    type_d = bus.RD ? REQ_READ : REQ_WRITE;
                    if (WAIT_CYC > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - 3'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ack_d = (state_q == ST_RESP);
        err_d = (state_q == ST_RESP) &&
                ((type_q == REQ_BAD) || out_of_range(addr_q, ADDR_BITS));

        // Read data is captured on the edge that enters RESP, from the
        // address being latched on that same edge when WAIT_CYC is 0.
        dout_d = dout_q;
        if ((state_q != ST_RESP) && (state_d == ST_RESP) && (type_d == REQ_READ))
            dout_d = out_of_range(addr_d, ADDR_BITS) ? '0 : rdata;
    end

    // A reset on the edge leaving RESP must also suppress the write.
    assign we = Reset && (state_q == ST_RESP) && (type_q == REQ_WRITE) &&
                !out_of_range(addr_q, ADDR_BITS);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            type_q  <= REQ_NONE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    cvp14_word_array #(.ADDR_BITS(ADDR_BITS)) u_array (
        .clk   (Clk1),
        .we    (we),
        .waddr (addr_q[ADDR_BITS-1:0]),
        .wdata (data_q),
        .raddr (addr_d[ADDR_BITS-1:0]),
        .rdata (rdata)
    );

    assign bus.DataOut = dout_q;
    assign bus.Ack     = ack_q;
    assign bus.Err     = err_q;
    assign bus.Busy    = (state_q != ST_IDLE);

endmodule
